tcp_vlg_opt_ser: RTL and testbench

//  TX-side TCP options serializer; the send-path counterpart of the RX options parser. Sits in the TCP
//  TX header assembler, after the fixed 20-byte header. Latches a tcp_opt_t snapshot, reports the

---
 rtl/tcp_vlg_opt_ser.sv | 243 ++++++++++++++++++++++++
 tb/tb_tcp_vlg_opt_ser.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tcp_vlg_opt_ser.sv
// TX TCP options serializer: latches a tcp_opt_t, reports len/offset, then streams
// NOP-padded option bytes one per clock under valid/ready.
package tcp_vlg_opt_pkg;
  typedef struct packed {
    logic [31:0] left;
    logic [31:0] right;
  } tcp_sack_blk_t;

  typedef struct packed {
    logic                      mss_pres;
    logic [15:0]               mss;
    logic                      wnd_pres;
    logic [7:0]                wnd;
    logic                      sack_perm_pres;
    logic                      timestamp_pres;
    logic [31:0]               snd;
    logic [31:0]               rec;
    logic                      sack_pres;
    logic [3:0]                block_pres;
    tcp_sack_blk_t [3:0]       block;
  } tcp_opt_t;
endpackage

module tcp_vlg_opt_ser
  import tcp_vlg_opt_pkg::*;
#(
  parameter int MAX_OPT_BYTES = 40,
  parameter int MAX_WIN_SCALE = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  tcp_opt_t   opt,
  output logic [5:0] len,
  output logic [3:0] offset,
  output logic       len_val,
  output logic [7:0] dat,
  output logic       val,
  input  logic       rdy,
  output logic       last,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, CALC, MSS, WND, SPERM, TS, SACK, FIN} state_t;

  state_t     state;
  logic [5:0] idx;
  tcp_opt_t   snap;
  logic [2:0] sack_n;
  logic [3:0] sack_sel;

  // Budget for the incoming request, evaluated on the accepting cycle.
  logic [2:0] in_cnt, in_fit, in_n, in_k;
  logic [6:0] in_used, in_rem;
  logic [5:0] in_len;
  logic [3:0] in_sel;

  always_comb begin
    in_cnt = '0;
    for (int i = 0; i < 4; i++) in_cnt = in_cnt + {2'b00, opt.block_pres[i]};
    in_used = (opt.mss_pres       ? 7'd4  : 7'd0) + (opt.wnd_pres       ? 7'd4 : 7'd0)
            + (opt.sack_perm_pres ? 7'd4  : 7'd0) + (opt.timestamp_pres ? 7'd12 : 7'd0);
    in_rem = 7'(MAX_OPT_BYTES) - in_used;
    in_fit = (in_rem >= 7'd12) ? 3'((in_rem - 7'd4) >> 3) : 3'd0;
    in_n   = opt.sack_pres ? ((in_cnt < in_fit) ? in_cnt : in_fit) : 3'd0;
    in_sel = '0;
    in_k   = '0;
    for (int i = 0; i < 4; i++) begin
      if (opt.block_pres[i] && in_k < in_n) begin
        in_sel[i] = 1'b1;
        in_k      = in_k + 3'd1;
      end
    end
    in_len = 6'(in_used + ((in_n != 3'd0) ? (7'd4 + {1'b0, in_n, 3'b000}) : 7'd0));
  end

  function automatic state_t next_opt(input state_t s, input logic [4:0] p);
    state_t r;
    r = FIN;
    if (s < SACK  && p[4]) r = SACK;
    if (s < TS    && p[3]) r = TS;
    if (s < SPERM && p[2]) r = SPERM;
    if (s < WND   && p[1]) r = WND;
    if (s < MSS   && p[0]) r = MSS;
    return r;
  endfunction

  function automatic logic [5:0] opt_size(input state_t s, input logic [2:0] n);
    case (s)
      MSS, WND, SPERM: return 6'd4;
      TS:              return 6'd12;
      SACK:            return 6'd4 + {n, 3'b000};
      default:         return 6'd0;
    endcase
  endfunction

  logic [4:0] pres;
  assign pres = {snap.sack_pres && (sack_n != 3'd0), snap.timestamp_pres,
                 snap.sack_perm_pres, snap.wnd_pres, snap.mss_pres};

  // Cursor of the byte to present after the current one.
  state_t     ns;
  logic [5:0] nidx;
  logic       nlast;

  always_comb begin
    if (state == CALC || idx == opt_size(state, sack_n) - 6'd1) begin
      ns   = next_opt(state, pres);
      nidx = '0;
    end else begin
      ns   = state;
      nidx = idx + 6'd1;
    end
    nlast = (ns != FIN) && (nidx == opt_size(ns, sack_n) - 6'd1) && (next_opt(ns, pres) == FIN);
  end

  logic [7:0]  nbyte, wscale, sack_byte;
  logic [1:0]  sk, blk;
  logic [2:0]  sb, scnt;
  logic [31:0] sword, tword;

  always_comb begin
    wscale = (snap.wnd > 8'(MAX_WIN_SCALE)) ? 8'(MAX_WIN_SCALE) : snap.wnd;
    sk     = 2'((nidx - 6'd4) >> 3);
    sb     = 3'(nidx - 6'd4);
    blk    = '0;
    scnt   = '0;
    // Map the block ordinal onto the k-th selected block index.
    for (int i = 0; i < 4; i++) begin
      if (sack_sel[i] && snap.block_pres[i]) begin
        if (scnt == {1'b0, sk}) blk = 2'(i);
        scnt = scnt + 3'd1;
      end
    end
    sword     = sb[2] ? snap.block[blk].right : snap.block[blk].left;
    sack_byte = 8'(sword >> {~sb[1:0], 3'b000});
    tword     = (nidx < 6'd8) ? snap.snd : snap.rec;
    nbyte     = 8'h00;
    case (ns)
      MSS:
        case (nidx)
          6'd0:    nbyte = 8'h02;
          6'd1:    nbyte = 8'h04;
          6'd2:    nbyte = snap.mss[15:8];
          default: nbyte = snap.mss[7:0];
        endcase
      WND:
        case (nidx)
          6'd0:       nbyte = 8'h01;
          6'd1, 6'd2: nbyte = 8'h03;
          default:    nbyte = wscale;
        endcase
      SPERM:
        case (nidx)
          6'd0, 6'd1: nbyte = 8'h01;
          6'd2:       nbyte = 8'h04;
          default:    nbyte = 8'h02;
        endcase
      TS:
        case (nidx)
          6'd0, 6'd1: nbyte = 8'h01;
          6'd2:       nbyte = 8'h08;
          6'd3:       nbyte = 8'h0A;
          default:    nbyte = 8'(tword >> {~nidx[1:0], 3'b000});
        endcase
      SACK:
        case (nidx)
          6'd0, 6'd1: nbyte = 8'h01;
          6'd2:       nbyte = 8'h05;
          6'd3:       nbyte = 8'd2 + {2'b00, sack_n, 3'b000};
          default:    nbyte = sack_byte;
        endcase
      default: nbyte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      snap     <= '0;
      sack_n   <= '0;
      sack_sel <= '0;
      len      <= '0;
      offset   <= 4'd5;
      len_val  <= 1'b0;
      dat      <= '0;
      val      <= 1'b0;
      last     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      len_val <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (start) begin
            snap     <= opt;
            sack_n   <= in_n;
            sack_sel <= in_sel;
            len      <= in_len;
            offset   <= 4'd5 + {2'b00, in_len[5:2]};
            len_val  <= 1'b1;
            busy     <= 1'b1;
            state    <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          state <= ns;
          idx   <= nidx;
          if (ns == FIN) begin
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            dat  <= nbyte;
            val  <= 1'b1;
            last <= nlast;
          end
        end
        default: begin
          if (val && rdy) begin
            if (last) begin
              val   <= 1'b0;
              last  <= 1'b0;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FIN;
            end else begin
              state <= ns;
              idx   <= nidx;
              dat   <= nbyte;
              last  <= nlast;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_vlg_opt_ser.sv
// Directed bench for tcp_vlg_opt_ser with hand-computed byte streams.
module tb_tcp_vlg_opt_ser;
  import tcp_vlg_opt_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, rdy;
  tcp_opt_t   opt;
  logic [5:0] len;
  logic [3:0] offset;
  logic       len_val, val, last, busy, done;
  logic [7:0] dat;

  always #5 clk = ~clk;

  tcp_vlg_opt_ser dut (
    .clk(clk), .rst(rst), .start(start), .opt(opt), .len(len), .offset(offset),
    .len_val(len_val), .dat(dat), .val(val), .rdy(rdy), .last(last), .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  tcp_opt_t c1, c3, c4, c5, c7;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
    end
  endtask

  task automatic start_case(input tcp_opt_t o, input logic [5:0] elen, input logic [3:0] eoff,
                            input string tag);
    opt = o;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    opt = '0;
    chk({tag, ".len_val"}, len_val, 1);
    chk({tag, ".len"}, len, elen);
    chk({tag, ".offset"}, offset, eoff);
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".no_val_calc"}, val, 0);
  endtask

  task automatic stream(input string tag, input bit rnd, input bit inj);
    int nlast = 0, stall = 0, spur = 0, cyc = 0, finished = 0, injd = 0;
    logic pv, pl, prdy;
    logic [7:0] pd;
    got.delete();
    for (int c = 0; c < 400; c++) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inj && injd == 0 && got.size() == 4) begin
        opt = c1;
        start = 1'b1;
        injd = 1;
      end else begin
        start = 1'b0;
      end
      pv = val; pd = dat; pl = last; prdy = rdy;
      @(posedge clk); #1;
      if (pv && prdy) begin
        got.push_back(pd);
        if (pl) nlast++;
      end
      if (pv && !prdy && (val !== 1'b1 || dat !== pd || last !== pl)) stall++;
      if (len_val) spur++;
      if (done) begin
        cyc = c;
        finished = 1;
        break;
      end
    end
    start = 1'b0;
    rdy = 1'b1;
    chk({tag, ".finished"}, finished, 1);
    chk({tag, ".count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s.byte%0d", tag, i + 1), got[i], exp_q[i]);
    chk({tag, ".nlast"}, nlast, (exp_q.size() != 0) ? 1 : 0);
    chk({tag, ".stall_stable"}, stall, 0);
    chk({tag, ".spurious_len_val"}, spur, 0);
    chk({tag, ".busy_at_done"}, busy, 0);
    chk({tag, ".val_at_done"}, val, 0);
    if (!rnd) chk({tag, ".done_cycle"}, cyc, exp_q.size());
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rdy = 1'b1; opt = '0;
    c1 = '0; c1.mss_pres = 1; c1.mss = 16'h05B4; c1.wnd_pres = 1; c1.wnd = 8'd7; c1.sack_perm_pres = 1;
    c3 = '0; c3.timestamp_pres = 1; c3.snd = 32'h11223344; c3.rec = 32'hAABBCCDD;
    c3.sack_pres = 1; c3.block_pres = 4'hF;
    c3.block[0] = '{32'h01020304, 32'h05060708};
    c3.block[1] = '{32'h11121314, 32'h15161718};
    c3.block[2] = '{32'h21222324, 32'h25262728};
    c3.block[3] = '{32'h31323334, 32'h35363738};
    c4 = '0; c4.wnd_pres = 1; c4.wnd = 8'd20;
    c5 = '0; c5.timestamp_pres = 1; c5.snd = 32'hDEADBEEF; c5.rec = 32'h01234567;
    c7 = c3; c7.timestamp_pres = 0; c7.block_pres = 4'b1010;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset.len", len, 0);
    chk("reset.offset", offset, 5);
    chk("reset.val", val, 0);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.last", last, 0);

    exp_q = '{8'h02, 8'h04, 8'h05, 8'hB4, 8'h01, 8'h03, 8'h03, 8'h07, 8'h01, 8'h01, 8'h04, 8'h02};
    start_case(c1, 6'd12, 4'd8, "syn");
    stream("syn", 0, 0);

    exp_q = {};
    start_case('0, 6'd0, 4'd5, "empty");
    stream("empty", 0, 0);

    exp_q = '{8'h01, 8'h01, 8'h08, 8'h0A, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
              8'h01, 8'h01, 8'h05, 8'h1A,
              8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
              8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18,
              8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
    start_case(c3, 6'd40, 4'd15, "ts_sack");
    stream("ts_sack", 0, 0);

    exp_q = '{8'h01, 8'h03, 8'h03, 8'h0E};
    start_case(c4, 6'd4, 4'd6, "wnd_clamp");
    stream("wnd_clamp", 0, 0);

    exp_q = '{8'h01, 8'h01, 8'h05, 8'h12,
              8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18,
              8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38};
    start_case(c7, 6'd20, 4'd10, "sparse_sack");
    stream("sparse_sack", 0, 0);

    exp_q = '{8'h01, 8'h01, 8'h08, 8'h0A, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    start_case(c5, 6'd12, 4'd8, "ts_stall");
    stream("ts_stall", 1, 1);
    opt = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("ts_stall.idle_busy", busy, 0);
    chk("ts_stall.idle_val", val, 0);
    chk("ts_stall.len_held", len, 12);

    // Abort case 1 while its fifth byte is on the bus, then replay it.
    start_case(c1, 6'd12, 4'd8, "abort");
    repeat (5) @(posedge clk);
    #1;
    chk("abort.byte5_dat", dat, 8'h01);
    chk("abort.byte5_val", val, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.val", val, 0);
    chk("abort.busy", busy, 0);
    chk("abort.last", last, 0);
    chk("abort.done", done, 0);
    exp_q = '{8'h02, 8'h04, 8'h05, 8'hB4, 8'h01, 8'h03, 8'h03, 8'h07, 8'h01, 8'h01, 8'h04, 8'h02};
    start_case(c1, 6'd12, 4'd8, "replay");
    stream("replay", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
